// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: shared TX state encoding, byte selectors and frame helpers for the UART ALU link.
// UART_TX_FLAGS_EN adds the flags byte states and widens the frame to three bytes.
package uart_alu_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        REGISTER = 4'd1,
        SEND_LSB = 4'd2,
        WAIT_LSB = 4'd3,
        GAP      = 4'd4,
        SEND_MSB = 4'd5,
        WAIT_MSB = 4'd6,
        DONE     = 4'd7
`ifdef UART_TX_FLAGS_EN
        ,
        SEND_FLG = 4'd8,
        WAIT_FLG = 4'd9
`endif
    } tx_state_t;

    typedef enum logic [1:0] {
        BYTE_LSB = 2'd0,
        BYTE_MSB = 2'd1,
        BYTE_FLG = 2'd2
    } byte_sel_t;

`ifdef UART_TX_FLAGS_EN
    localparam int FRAME_BYTES = 3;
`else
    localparam int FRAME_BYTES = 2;
`endif

    function automatic logic is_send(tx_state_t s);
`ifdef UART_TX_FLAGS_EN
        return s == SEND_LSB || s == SEND_MSB || s == SEND_FLG;
`else
        return s == SEND_LSB || s == SEND_MSB;
`endif
    endfunction

    function automatic logic [7:0] select_byte(byte_sel_t sel, logic [15:0] result, logic [3:0] flags);
        return sel == BYTE_MSB ? result[15:8] : sel == BYTE_FLG ? {4'h0, flags} : result[7:0];
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: trigger/result side and byte-transmitter handshake of the TX controller.
interface uart_tx_ctrl_if;
    logic        trigger;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;

    modport master (
        output trigger, result, flags, tx_busy,
        input  tx_start, tx_data, busy, done
    );

    modport slave (
        input  trigger, result, flags, tx_busy,
        output tx_start, tx_data, busy, done
    );
endinterface

// File: rtl/delay_counter.sv
// delay_counter: counts 0..count-1 while enabled; tc flags the last cycle of the run.
module delay_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] count,
    output logic         tc
);
    logic [W-1:0] value;

    assign tc = enable && value == count - W'(1);

    always_ff @(posedge clk)
        if (reset || clear) value <= '0;
        else if (enable && !tc) value <= value + W'(1);
endmodule

// File: rtl/registros_n_bit.sv
// registros_n_bit: N-bit register with synchronous clear and load enable.
module registros_n_bit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk)
        if (reset) q <= '0;
        else if (load) q <= d;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: latches the ALU result on trigger and sends it LSB then MSB over a start/busy byte handshake.
// Define UART_TX_FLAGS_EN to append a third byte {4'h0, flags} after the MSB.
module uart_tx_ctrl
    import uart_alu_pkg::*;
#(
    parameter int WAIT_FOR_REGISTER_DELAY = 100,
    parameter int INTER_BYTE_DELAY        = 0
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_ctrl_if.slave    bus,
    output logic [3:0]       LED
);
    localparam int REG_CYCLES = WAIT_FOR_REGISTER_DELAY > 0 ? WAIT_FOR_REGISTER_DELAY : 1;
    localparam int MAX_CYCLES = REG_CYCLES > INTER_BYTE_DELAY ? REG_CYCLES : INTER_BYTE_DELAY;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] REG_COUNT = CW'(REG_CYCLES);
    localparam logic [CW-1:0] GAP_COUNT = CW'(INTER_BYTE_DELAY);

    tx_state_t   state, state_next, resume;
    byte_sel_t   byte_sel;
    logic        accept, cnt_tc, load_byte;
    logic [15:0] res_q;
    logic [3:0]  flg_q;
    logic [7:0]  data_q;

    assign accept    = state == IDLE && bus.trigger;
    assign load_byte = state_next != state && is_send(state_next);
    assign byte_sel  = state_next == SEND_MSB ? BYTE_MSB : state_next == SEND_LSB ? BYTE_LSB : BYTE_FLG;

    registros_n_bit #(.N(16)) u_result (
        .clk  (clk),
        .reset(reset),
        .load (accept),
        .d    (bus.result),
        .q    (res_q)
    );

    registros_n_bit #(.N(4)) u_flags (
        .clk  (clk),
        .reset(reset),
        .load (accept),
        .d    (bus.flags),
        .q    (flg_q)
    );

    // Every state change restarts the run, so REGISTER and GAP always begin from zero.
    delay_counter #(.W(CW)) u_delay (
        .clk   (clk),
        .reset (reset),
        .clear (state_next != state),
        .enable(state == REGISTER || state == GAP),
        .count (state == GAP ? GAP_COUNT : REG_COUNT),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= state_next;

    // GAP is shared between bytes; remember which SEND state it hands over to.
    always_ff @(posedge clk)
        if (reset) resume <= SEND_MSB;
        else if (state == WAIT_LSB) resume <= SEND_MSB;
`ifdef UART_TX_FLAGS_EN
        else if (state == WAIT_MSB) resume <= SEND_FLG;
`endif

    always_ff @(posedge clk)
        if (reset) data_q <= '0;
        else if (load_byte) data_q <= select_byte(byte_sel, res_q, flg_q);

    always_comb begin
        state_next   = state;
        bus.tx_start = is_send(state);
        bus.tx_data  = data_q;
        bus.busy     = state != IDLE;
        bus.done     = state == DONE;
        LED          = state;
        case (state)
            IDLE:     state_next = bus.trigger ? REGISTER : IDLE;
            REGISTER: state_next = cnt_tc ? SEND_LSB : REGISTER;
            SEND_LSB: state_next = bus.tx_busy ? WAIT_LSB : SEND_LSB;
            WAIT_LSB: state_next = bus.tx_busy ? WAIT_LSB : INTER_BYTE_DELAY > 0 ? GAP : SEND_MSB;
            GAP:      state_next = cnt_tc ? resume : GAP;
            SEND_MSB: state_next = bus.tx_busy ? WAIT_MSB : SEND_MSB;
`ifdef UART_TX_FLAGS_EN
            WAIT_MSB: state_next = bus.tx_busy ? WAIT_MSB : INTER_BYTE_DELAY > 0 ? GAP : SEND_FLG;
            SEND_FLG: state_next = bus.tx_busy ? WAIT_FLG : SEND_FLG;
            WAIT_FLG: state_next = bus.tx_busy ? WAIT_FLG : DONE;
`else
            WAIT_MSB: state_next = bus.tx_busy ? WAIT_MSB : DONE;
`endif
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    a_start_held: assert property (@(posedge clk) disable iff (reset)
        bus.tx_start && !bus.tx_busy |=> bus.tx_start && $stable(bus.tx_data));

    a_done_pulse: assert property (@(posedge clk) disable iff (reset)
        bus.done |=> !bus.done);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: table-driven frames with a byte scoreboard, plus delay, stall, ignore and reset sequences.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;
    import uart_alu_pkg::*;

    typedef struct {
        logic [15:0] r;
        logic [3:0]  f;
        logic [7:0]  lsb;
        logic [7:0]  msb;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] led0, led1;
    int         tests = 0;
    int         fails = 0;
    int         sent0 = 0, done0 = 0, bcnt0 = 0;
    int         done1 = 0, bcnt1 = 0;
    bit         stall0 = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got1[$];

    uart_tx_ctrl_if b0();
    uart_tx_ctrl_if b1();

    uart_tx_ctrl #(.WAIT_FOR_REGISTER_DELAY(5), .INTER_BYTE_DELAY(2)) u0 (
        .clk  (clk),
        .reset(reset),
        .bus  (b0),
        .LED  (led0)
    );

    uart_tx_ctrl #(.WAIT_FOR_REGISTER_DELAY(0), .INTER_BYTE_DELAY(0)) u1 (
        .clk  (clk),
        .reset(reset),
        .bus  (b1),
        .LED  (led1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model for u0: accepts at the negedge, busy for 10 cycles, checks against the scoreboard.
    always @(negedge clk) begin
        if (b0.done === 1'b1) done0++;
        if (bcnt0 > 0) bcnt0--;
        else if (b0.tx_start === 1'b1 && !stall0) begin
            sent0++;
            chk("byte_queued", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("tx_data", 32'(b0.tx_data), 32'(exp_q.pop_front()));
            bcnt0 = 10;
        end
        b0.tx_busy = bcnt0 > 0;
    end

    always @(negedge clk) begin
        if (b1.done === 1'b1) done1++;
        if (bcnt1 > 0) bcnt1--;
        else if (b1.tx_start === 1'b1) begin
            got1.push_back(b1.tx_data);
            bcnt1 = 3;
        end
        b1.tx_busy = bcnt1 > 0;
    end

    task automatic expect0(input logic [15:0] r, input logic [3:0] f);
        exp_q.push_back(r[7:0]);
        exp_q.push_back(r[15:8]);
`ifdef UART_TX_FLAGS_EN
        exp_q.push_back({4'h0, f});
`endif
    endtask

    task automatic pulse0(input logic [15:0] r, input logic [3:0] f);
        @(negedge clk);
        b0.result  = r;
        b0.flags   = f;
        b0.trigger = 1'b1;
        @(negedge clk);
        b0.trigger = 1'b0;
    endtask

    task automatic wait_idle0(input string name);
        for (int i = 0; i < 500 && b0.busy !== 1'b0; i++) @(negedge clk);
        chk(name, 32'(b0.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v[6];
        int   n, d, s;
        bit   bad;
        v[0] = '{16'hBEEF, 4'h3, 8'hEF, 8'hBE};
        v[1] = '{16'h1234, 4'h5, 8'h34, 8'h12};
        v[2] = '{16'h0000, 4'h0, 8'h00, 8'h00};
        v[3] = '{16'hFFFF, 4'hF, 8'hFF, 8'hFF};
        v[4] = '{16'hA55A, 4'h9, 8'h5A, 8'hA5};
        v[5] = '{16'h0001, 4'hA, 8'h01, 8'h00};
        b0.trigger = 1'b0; b0.result = '0; b0.flags = '0;
        b1.trigger = 1'b0; b1.result = '0; b1.flags = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_start", 32'(b0.tx_start), 0);
        chk("rst_tx_data", 32'(b0.tx_data), 0);
        chk("rst_busy", 32'(b0.busy), 0);
        chk("rst_done", 32'(b0.done), 0);
        chk("rst_led", 32'(led0), 0);
        chk("rst_busy_u1", 32'(b1.busy), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            d = done0;
            s = sent0;
            exp_q.push_back(v[i].lsb);
            exp_q.push_back(v[i].msb);
`ifdef UART_TX_FLAGS_EN
            exp_q.push_back({4'h0, v[i].f});
`endif
            pulse0(v[i].r, v[i].f);
            wait_idle0("frame_idle");
            chk("frame_done_once", 32'(done0 - d), 1);
            chk("frame_bytes", 32'(sent0 - s), 32'(FRAME_BYTES));
            chk("frame_queue_drained", 32'(exp_q.size()), 0);
        end

        expect0(16'h5AA5, 4'h1);
        @(negedge clk);
        b0.result = 16'h5AA5; b0.flags = 4'h1; b0.trigger = 1'b1;
        @(posedge clk);
        #1 b0.trigger = 1'b0;
        n = 0;
        while (b0.tx_start !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency_d5", 32'(n + 1), 6);
        wait_idle0("latency_d5_idle");

        d = done1;
        @(negedge clk);
        b1.result = 16'hC3A5; b1.flags = 4'h6; b1.trigger = 1'b1;
        @(posedge clk);
        #1 b1.trigger = 1'b0;
        n = 0;
        while (b1.tx_start !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency_d0", 32'(n + 1), 2);
        for (int i = 0; i < 200 && b1.busy !== 1'b0; i++) @(negedge clk);
        chk("u1_idle", 32'(b1.busy), 0);
        chk("u1_done_once", 32'(done1 - d), 1);
        chk("u1_bytes", 32'(got1.size()), 32'(FRAME_BYTES));
        if (got1.size() >= 2) begin
            chk("u1_lsb", 32'(got1[0]), 32'h A5);
            chk("u1_msb", 32'(got1[1]), 32'h C3);
        end
`ifdef UART_TX_FLAGS_EN
        if (got1.size() >= 3) chk("u1_flg", 32'(got1[2]), 32'h06);
`endif

        expect0(16'hBEEF, 4'h0);
        stall0 = 1'b1;
        s = sent0;
        d = done0;
        pulse0(16'hBEEF, 4'h0);
        for (int i = 0; i < 50 && b0.tx_start !== 1'b1; i++) @(negedge clk);
        chk("stall_start_seen", 32'(b0.tx_start), 1);
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (b0.tx_start !== 1'b1 || b0.tx_data !== 8'hEF) bad = 1'b1;
        end
        chk("stall_held_stable", 32'(bad), 0);
        chk("stall_no_send", 32'(sent0 - s), 0);
        chk("stall_led", 32'(led0), 32'(SEND_LSB));
        stall0 = 1'b0;
        wait_idle0("stall_idle");
        chk("stall_done", 32'(done0 - d), 1);
        chk("stall_bytes", 32'(sent0 - s), 32'(FRAME_BYTES));

        expect0(16'hBEEF, 4'h2);
        s = sent0;
        d = done0;
        pulse0(16'hBEEF, 4'h2);
        repeat (12) @(negedge clk);
        chk("busy_mid_frame", 32'(b0.busy), 1);
        pulse0(16'h1234, 4'h5);
        wait_idle0("ignore_idle");
        repeat (20) @(negedge clk);
        chk("ignore_bytes", 32'(sent0 - s), 32'(FRAME_BYTES));
        chk("ignore_done", 32'(done0 - d), 1);
        chk("ignore_no_frame", 32'(b0.busy), 0);
        chk("ignore_queue", 32'(exp_q.size()), 0);
        expect0(16'h1234, 4'h5);
        d = done0;
        pulse0(16'h1234, 4'h5);
        wait_idle0("retrigger_idle");
        chk("retrigger_done", 32'(done0 - d), 1);
        chk("retrigger_queue", 32'(exp_q.size()), 0);

        expect0(16'h00FF, 4'h0);
        pulse0(16'h00FF, 4'h0);
        for (int i = 0; i < 500 && b0.done !== 1'b1; i++) @(negedge clk);
        chk("done_seen", 32'(b0.done), 1);
        b0.result = 16'hDEAD;
        b0.trigger = 1'b1;
        @(negedge clk);
        b0.trigger = 1'b0;
        chk("trig_in_done_busy", 32'(b0.busy), 0);
        repeat (10) @(negedge clk);
        chk("trig_in_done_no_frame", 32'(b0.busy), 0);

        expect0(16'hCAFE, 4'h7);
        d = done0;
        pulse0(16'hCAFE, 4'h7);
        for (int i = 0; i < 500 && led0 !== 4'(WAIT_MSB); i++) @(negedge clk);
        chk("reach_wait_msb", 32'(led0), 32'(WAIT_MSB));
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tx_start", 32'(b0.tx_start), 0);
        chk("midrst_busy", 32'(b0.busy), 0);
        chk("midrst_led", 32'(led0), 32'(IDLE));
        chk("midrst_tx_data", 32'(b0.tx_data), 0);
        chk("midrst_done", 32'(b0.done), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", 32'(done0 - d), 0);
        chk("midrst_stays_idle", 32'(b0.busy), 0);
        exp_q.delete();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side controller for the UART ALU link. On a one-cycle `trigger` from the receive controller, it latches the 16-bit ALU result and sends it to the byte-level UART transmitter as LSB then MSB. It uses a start/busy handshake with that transmitter. It sits between the ALU output and the UART TX serializer, mirroring the receive controller that collects OP1, OP2 and CMD.

Parameters:
- WAIT_FOR_REGISTER_DELAY, 100, clock cycles spent in REGISTER after latching, before the first byte starts; a value of 0 is treated as 1.
- INTER_BYTE_DELAY, 0, idle cycles inserted in GAP between consecutive bytes; 0 skips GAP entirely.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- trigger, input, 1, single-cycle pulse requesting transmission of `result`.
- result, input, 16, ALU result; sampled only on an accepted trigger.
- flags, input, 4, ALU flags; sampled with `result` (used only with UART_TX_FLAGS_EN).
- tx_busy, input, 1, UART transmitter busy (high while shifting a byte).
- tx_start, output, 1, request to the transmitter to send `tx_data`.
- tx_data, output, 8, byte presented to the transmitter.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse after the final byte completes.
- LED, output, 4, current state encoding, for board debug.

Behaviour:
- Reset values (sampled at posedge with reset=1): state=IDLE; tx_start=0, tx_data=0, busy=0, done=0; latched result/flags=0; counters=0.
- States: IDLE, REGISTER, SEND_LSB, WAIT_LSB, GAP, SEND_MSB, WAIT_MSB, DONE. SEND_FLG and WAIT_FLG exist only with the optional feature.
- IDLE:
  - trigger=1 latches result and flags at that edge; next state REGISTER.
  - trigger=0 stays in IDLE.
- REGISTER: counter runs 0..max(1,WAIT_FOR_REGISTER_DELAY)-1, then SEND_LSB.
- SEND_x:
  - tx_start=1 and tx_data = selected byte.
  - tx_start is held until tx_busy=1 is sampled, then WAIT_x (level-until-accept handshake; no timeout).
- WAIT_x:
  - tx_start=0; tx_data is held at the same byte.
  - Leave when tx_busy=0 is sampled.
  - After WAIT_LSB: go to GAP if INTER_BYTE_DELAY>0, else SEND_MSB.
  - After WAIT_MSB: go to DONE, or to GAP then SEND_FLG under the macro.
- GAP: counter runs 0..INTER_BYTE_DELAY-1, then the next SEND state.
- DONE: done=1 for exactly one cycle; next state IDLE.
- Byte selection: LSB = result[7:0]; MSB = result[15:8]; FLG = {4'h0, flags}.
- Latency with tx_busy rising the cycle after tx_start: first tx_start occurs WAIT_FOR_REGISTER_DELAY+1 cycles after the trigger edge.
- tx_data updates only on entry to a SEND state and is otherwise held. It must stay stable while tx_start=1.
- trigger while busy=1 is ignored (not queued); the latched result is unchanged.
- trigger in the same cycle as DONE is ignored; it is accepted only in IDLE.
- tx_busy already high on entry to SEND_x: accepted immediately. A bench with an idle transmitter must not see this.
- Reset mid-frame: all outputs return to reset values at the next edge, including tx_start dropping immediately. Any byte already inside the transmitter completes on its own.
- LED = state encoding.

Optional Feature:
- Macro UART_TX_FLAGS_EN.
- Defined: after the MSB, a third byte {4'h0, flags} is sent via SEND_FLG/WAIT_FLG, preceded by GAP if INTER_BYTE_DELAY>0. done then follows WAIT_FLG.
- Undefined: the flags port exists but is unused; the frame is exactly 2 bytes.

Decomposition:
- Shared package uart_alu_pkg holds:
  - the tx_state_t enum (logic [3:0]);
  - byte-select constants BYTE_LSB, BYTE_MSB, BYTE_FLG;
  - localparam FRAME_BYTES (2, or 3 when UART_TX_FLAGS_EN is defined).
- The result/flags latch reuses registros_n_bit (N=16 and N=4) with load = accepted trigger.
- The delay counter is a natural sub-module: delay_counter, with clk, reset, clear, enable, count, and a terminal-count output.

Test Plan:
- Nominal: result=16'hBEEF, trigger pulse, transmitter model with 10-cycle busy -> tx_start with tx_data=8'hEF, then tx_start with 8'hBE, then done pulse once; busy low afterwards.
- Delay check: WAIT_FOR_REGISTER_DELAY=5 -> first tx_start exactly 6 cycles after the trigger edge; WAIT_FOR_REGISTER_DELAY=0 -> 2 cycles.
- Handshake stall: hold tx_busy=0 for 50 cycles after tx_start -> tx_start and tx_data=8'hEF stay asserted and stable; the MSB is not sent early.
- Trigger while busy: second trigger with result=16'h1234 mid-frame -> frame still sends EF, BE; no second frame; then trigger in IDLE sends 34, 12.
- Reset mid-frame: reset asserted during WAIT_MSB -> next edge tx_start=0, busy=0, LED=IDLE encoding; no done pulse.
- UART_TX_FLAGS_EN defined, flags=4'hA, result=16'h0001 -> bytes 01, 00, 0A, then done.
